// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared constants and helpers for the EX/MEM pipeline register.
//   - stall vector width and bit positions driven by the ctrl block
//   - default datapath widths
//   - a small subset of ALU opcodes used by MEM-side load/store decode
//   - update-control encoding and its priority decode (rst > flush > stall > normal)
package ex_mem_pkg;

  localparam int STALL_W   = 6;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;

  localparam int REG_W_DEF  = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int OP_W_DEF   = 8;
  localparam int CNT_W_DEF  = 2;

  // Load/store opcodes that travel through this register to MEM.
  localparam logic [7:0] ALU_NOP  = 8'h00;
  localparam logic [7:0] ALU_LB   = 8'he0;
  localparam logic [7:0] ALU_LH   = 8'he1;
  localparam logic [7:0] ALU_LW   = 8'he3;
  localparam logic [7:0] ALU_SB   = 8'he8;
  localparam logic [7:0] ALU_SH   = 8'he9;
  localparam logic [7:0] ALU_SW   = 8'heb;
  localparam logic [7:0] ALU_MADD = 8'ha6;
  localparam logic [7:0] ALU_MSUB = 8'haa;

  // What the register does on the next edge.
  //   CTL_CLEAR   : everything to zero (reset or flush)
  //   CTL_HOLD    : everything keeps its value (EX and MEM both stalled)
  //   CTL_BUBBLE  : MEM bundle zeroed, accumulation state forwarded back to EX
  //   CTL_CAPTURE : MEM bundle loaded from EX, accumulation state cleared
  typedef enum logic [1:0] {
    CTL_CLEAR   = 2'd0,
    CTL_HOLD    = 2'd1,
    CTL_BUBBLE  = 2'd2,
    CTL_CAPTURE = 2'd3
  } ctl_e;

  // stall_ex=0 with stall_mem=1 cannot come from ctrl; it is treated as a
  // hold so a downstream stall is never lost.
  function automatic ctl_e decode_ctl(input logic rst, input logic flush,
                                      input logic stall_ex, input logic stall_mem);
    if (rst)                      return CTL_CLEAR;
    else if (flush)               return CTL_CLEAR;
    else if (stall_mem)           return CTL_HOLD;
    else if (stall_ex)            return CTL_BUBBLE;
    else                          return CTL_CAPTURE;
  endfunction

endpackage

// File: rtl/ex_mem.sv
// ex_mem: EX -> MEM pipeline register of the 5-stage MIPS core.
//   Inputs : clk, rst (sync, active-high), stall[5:0], flush,
//            ex_* result bundle (GPR write, HI/LO write, aluop, address, store data),
//            hilo_temp_i / cnt_i multi-cycle accumulation state from EX.
//   Outputs: mem_* registered bundle toward MEM,
//            hilo_temp_o / cnt_o accumulation state returned to EX.
// All outputs are registered; latency is exactly one cycle. A bubble is the
// all-zero bundle, so mem_wreg/mem_whilo are 0 and MEM/WB commit nothing.
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int REG_W  = REG_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int OP_W   = OP_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_W-1:0]   stall,
  input  logic                 flush,
  input  logic [ADDR_W-1:0]    ex_wd,
  input  logic                 ex_wreg,
  input  logic [REG_W-1:0]     ex_wdata,
  input  logic                 ex_whilo,
  input  logic [REG_W-1:0]     ex_hi,
  input  logic [REG_W-1:0]     ex_lo,
  input  logic [OP_W-1:0]      ex_aluop,
  input  logic [REG_W-1:0]     ex_mem_addr,
  input  logic [REG_W-1:0]     ex_reg2,
  input  logic [2*REG_W-1:0]   hilo_temp_i,
  input  logic [CNT_W-1:0]     cnt_i,
  output logic [ADDR_W-1:0]    mem_wd,
  output logic                 mem_wreg,
  output logic [REG_W-1:0]     mem_wdata,
  output logic                 mem_whilo,
  output logic [REG_W-1:0]     mem_hi,
  output logic [REG_W-1:0]     mem_lo,
  output logic [OP_W-1:0]      mem_aluop,
  output logic [REG_W-1:0]     mem_mem_addr,
  output logic [REG_W-1:0]     mem_reg2,
  output logic [2*REG_W-1:0]   hilo_temp_o,
  output logic [CNT_W-1:0]     cnt_o
);

  ctl_e ctl;

  // Only the EX and MEM stall bits matter here; the rest belong to other stages.
  logic unused_stall;
  assign unused_stall = ^{stall[STALL_W-1:STALL_MEM+1], stall[STALL_EX-1:0]};

  always_comb begin
    ctl = decode_ctl(rst, flush, stall[STALL_EX], stall[STALL_MEM]);
  end

  always_ff @(posedge clk) begin
    case (ctl)
      CTL_CLEAR, CTL_BUBBLE: begin
        mem_wd       <= '0;
        mem_wreg     <= 1'b0;
        mem_wdata    <= '0;
        mem_whilo    <= 1'b0;
        mem_hi       <= '0;
        mem_lo       <= '0;
        mem_aluop    <= '0;
        mem_mem_addr <= '0;
        mem_reg2     <= '0;
        // A bubble keeps the partial product alive for EX's next cycle;
        // reset/flush discard it.
        if (ctl == CTL_BUBBLE) begin
          hilo_temp_o <= hilo_temp_i;
          cnt_o       <= cnt_i;
        end else begin
          hilo_temp_o <= '0;
          cnt_o       <= '0;
        end
      end
      CTL_CAPTURE: begin
        mem_wd       <= ex_wd;
        mem_wreg     <= ex_wreg;
        mem_wdata    <= ex_wdata;
        mem_whilo    <= ex_whilo;
        mem_hi       <= ex_hi;
        mem_lo       <= ex_lo;
        mem_aluop    <= ex_aluop;
        mem_mem_addr <= ex_mem_addr;
        mem_reg2     <= ex_reg2;
        // Instruction left EX: no accumulation carries into the next one.
        hilo_temp_o  <= '0;
        cnt_o        <= '0;
      end
      default: ; // CTL_HOLD: every register keeps its value
    endcase
  end

`ifndef SYNTHESIS
  // ctrl must never stall MEM while letting EX advance.
  illegal_stall: assert property (@(posedge clk) disable iff (rst)
    !(!stall[STALL_EX] && stall[STALL_MEM]));
`endif

endmodule

// File: doc/ex_mem.md
Name: ex_mem

Overview:
- Pipeline register between the execute stage and the memory-access stage of the 5-stage MIPS core.
- Captures EX results each cycle: GPR write-back, HI/LO write, load/store operands and ALU opcode.
- Applies stall/flush control. Bubble = all-zero bundle.
- Carries multi-cycle accumulation state (64-bit intermediate product plus cycle counter) back to EX, for MADD/MSUB-class instructions that occupy EX for 2 cycles.

Parameters:
- REG_W, 32, GPR/HI/LO data width
- ADDR_W, 5, GPR index width
- OP_W, 8, aluop width (matches ALU_* codes)
- CNT_W, 2, multi-cycle counter width

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  reset; synchronous, active-high
- stall  in  6  per-stage stall vector from ctrl; bit3 = EX stalled, bit4 = MEM stalled
- flush  in  1  exception flush; kills the instruction being captured
- ex_wd  in  ADDR_W  destination GPR
- ex_wreg  in  1  GPR write enable
- ex_wdata  in  REG_W  GPR write data
- ex_whilo  in  1  HI/LO write enable
- ex_hi  in  REG_W  HI write value
- ex_lo  in  REG_W  LO write value
- ex_aluop  in  OP_W  opcode forwarded for load/store decode
- ex_mem_addr  in  REG_W  effective address
- ex_reg2  in  REG_W  store data
- hilo_temp_i  in  2*REG_W  EX intermediate product
- cnt_i  in  CNT_W  EX multi-cycle counter
- mem_wd  out  ADDR_W  registered ex_wd
- mem_wreg  out  1  registered ex_wreg
- mem_wdata  out  REG_W  registered ex_wdata
- mem_whilo  out  1  registered ex_whilo
- mem_hi  out  REG_W  registered ex_hi
- mem_lo  out  REG_W  registered ex_lo
- mem_aluop  out  OP_W  registered ex_aluop
- mem_mem_addr  out  REG_W  registered ex_mem_addr
- mem_reg2  out  REG_W  registered ex_reg2
- hilo_temp_o  out  2*REG_W  intermediate product returned to EX
- cnt_o  out  CNT_W  counter returned to EX

Behaviour:
- All state updates on the rising edge of clk. No combinational path from inputs to outputs; latency is exactly 1 cycle.
- Priority, highest first: rst > flush > stall rules > normal.
- rst=1: every output 0 next edge, including hilo_temp_o=0 and cnt_o=0. rst mid multi-cycle op discards the partial product.
- flush=1 (rst=0): every output 0, including hilo_temp_o/cnt_o. Flush overrides any stall.
- stall[3]=1 and stall[4]=0 (EX held, MEM advances):
  - MEM bundle (mem_*) driven to bubble, all zero.
  - hilo_temp_o<=hilo_temp_i, cnt_o<=cnt_i, so EX sees its partial result next cycle.
- stall[3]=1 and stall[4]=1: all outputs hold their current values, including hilo_temp_o/cnt_o.
- stall[3]=0:
  - Normal capture: every mem_* output <= its ex_* input.
  - hilo_temp_o<=0, cnt_o<=0, clearing accumulation state between instructions.
- stall[3]=0 and stall[4]=1 is illegal: ctrl never produces it. Required response is the hold rule; an assertion flags it.
- Bubble invariant: mem_wreg=0 and mem_whilo=0 whenever a bubble is inserted, so MEM/WB perform no architectural write.
- Data passes through unmodified. No width conversion; no sign handling.

Decomposition:
- ALU_* opcodes and stall bit indices (STALL_EX=3, STALL_MEM=4) live in defines.v.
- No sub-module. A single always block with the priority chain above is natural.
- Optional: a generic dff_en_clr cell may be reused, but this is not required.

Test Plan:
- Reset: rst=1 with all inputs 0xFFFFFFFF for 1 cycle -> every output 0, hilo_temp_o=0, cnt_o=0.
- Pass-through: ex_wd=5'd3, ex_wreg=1, ex_wdata=32'h1234_5678, stall=0 -> one cycle later mem_wd=3, mem_wreg=1, mem_wdata=32'h1234_5678, cnt_o=0.
- MADD 2-cycle:
  - Cycle 1: stall=6'b001111, hilo_temp_i=64'h0000_0001_0000_0002, cnt_i=1, ex_wreg=1 -> next cycle mem_wreg=0, mem_whilo=0, hilo_temp_o=64'h0000_0001_0000_0002, cnt_o=1.
  - Cycle 2: stall=0 -> mem_* capture EX values; cnt_o=0.
- Double stall: after a capture with mem_wdata=32'hA5A5_A5A5, apply stall=6'b011111 for 3 cycles with changing inputs -> mem_wdata stays 32'hA5A5_A5A5 and hilo_temp_o/cnt_o are unchanged.
- Flush over stall: stall=6'b001111, flush=1, cnt_i=1 -> all outputs 0, cnt_o=0.
- Reset over flush: rst=1, flush=1, stall=6'b011111 with a nonzero held state -> all outputs 0 next edge.
